// File: rtl/counter_pkg.sv
// counter_pkg: shared state encodings and typedefs for the up/down counter family.
package counter_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } dn_state_t;
   typedef enum logic [1:0] {
      UP_IDLE  = 2'b00,
      UP_COUNT = 2'b01,
      UP_WRAP  = 2'b10
   } up_state_t;
   typedef struct packed {
      logic       wrap;
      logic       busy;
      up_state_t  state;
   } up_status_t;
endpackage

// File: rtl/down_counter_n.sv
// down_counter_n: loadable down counter with IDLE/RUN/DONE FSM and terminal-count pulse.
// Defining DOWN_COUNTER_RELOAD_EN turns expiry into a periodic reload of the last loaded value.
module down_counter_n
   import counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         enable,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         busy,
   output logic         done
);
   localparam logic [N-1:0] ONE = 1;
   dn_state_t    state_q;
   logic [N-1:0] count_q;
   logic         tc_q;
   logic         last_d;
`ifdef DOWN_COUNTER_RELOAD_EN
   logic [N-1:0] reload_q;
`endif
   assign last_d = (count_q == ONE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         tc_q     <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         tc_q <= 1'b0;
         if (load) begin
            count_q <= load_val;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_q <= load_val;
`endif
            if (load_val == '0) begin
               state_q <= DONE;
               tc_q    <= 1'b1;
            end else begin
               state_q <= RUN;
            end
         end else if (state_q == RUN && enable) begin
            if (!last_d) begin
               count_q <= count_q - ONE;
            end else begin
               tc_q <= 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
               count_q <= reload_q;
`else
               count_q <= '0;
               state_q <= DONE;
`endif
            end
         end
      end
   end
   // busy/done decode the registered state directly, so they change with it.
   assign count = count_q;
   assign tc    = tc_q;
   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
endmodule

// File: tb/tb_down_counter_n.sv
// tb_down_counter_n: directed scoreboard bench for down_counter_n (N=4).
// Reload-mode checks are built when DOWN_COUNTER_RELOAD_EN is defined.
module tb_down_counter_n;
   logic       clk;
   logic       rst_n;
   logic       load;
   logic [3:0] load_val;
   logic       enable;
   logic [3:0] count;
   logic       tc;
   logic       busy;
   logic       done;

   typedef struct {
      string      tag;
      logic [6:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   down_counter_n #(.N(4)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
      .enable(enable), .count(count), .tc(tc), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input int c, input logic t, input logic b, input logic d);
      exp_t e;
      e.tag = tag;
      e.v   = {4'(c), t, b, d};
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t       e;
      logic [6:0] obs;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard: no expected entry for count=%0d", count);
         return;
      end
      e   = sb.pop_front();
      obs = {count, tc, busy, done};
      assert (obs === e.v) else begin
         n_fail++;
         $error("FAIL %s: observed count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                e.tag, obs[6:3], obs[2], obs[1], obs[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      end
   endtask

   task automatic cyc(input string tag, input logic ld, input int val, input logic en,
                      input int c, input logic t, input logic b, input logic d);
      @(negedge clk);
      load     = ld;
      load_val = 4'(val);
      enable   = en;
      push(tag, c, t, b, d);
      @(posedge clk);
      #1;
      check();
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; load_val = '0; enable = 1'b0;
      #3;
      push("reset", 0, 0, 0, 0);
      check();
      @(negedge clk);
      rst_n = 1'b1;
      cyc("idle_ignores_en", 0, 0, 1, 0, 0, 0, 0);
`ifndef DOWN_COUNTER_RELOAD_EN
      cyc("ld5", 1, 5, 1, 5, 0, 1, 0);
      cyc("run4", 0, 0, 1, 4, 0, 1, 0);
      cyc("run3", 0, 0, 1, 3, 0, 1, 0);
      cyc("run2", 0, 0, 1, 2, 0, 1, 0);
      cyc("run1", 0, 0, 1, 1, 0, 1, 0);
      cyc("run0_tc", 0, 0, 1, 0, 1, 0, 1);
      cyc("done_hold", 0, 0, 1, 0, 0, 0, 1);
      cyc("ld3", 1, 3, 0, 3, 0, 1, 0);
      cyc("tog_en1_a", 0, 0, 1, 2, 0, 1, 0);
      cyc("tog_en0_a", 0, 0, 0, 2, 0, 1, 0);
      cyc("tog_en1_b", 0, 0, 1, 1, 0, 1, 0);
      cyc("tog_en0_b", 0, 0, 0, 1, 0, 1, 0);
      cyc("tog_en1_c", 0, 0, 1, 0, 1, 0, 1);
      cyc("ld6", 1, 6, 1, 6, 0, 1, 0);
      cyc("run5", 0, 0, 1, 5, 0, 1, 0);
      cyc("run4b", 0, 0, 1, 4, 0, 1, 0);
      cyc("ld9_over_en", 1, 9, 1, 9, 0, 1, 0);
      cyc("run8", 0, 0, 1, 8, 0, 1, 0);
      cyc("ld0", 1, 0, 1, 0, 1, 0, 1);
      for (int i = 0; i < 10; i++) cyc("ld0_hold", 0, 0, 1, 0, 0, 0, 1);
      cyc("ld4", 1, 4, 0, 4, 0, 1, 0);
      cyc("run3c", 0, 0, 1, 3, 0, 1, 0);
      cyc("run2c", 0, 0, 1, 2, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      push("async_rst", 0, 0, 0, 0);
      check();
      cyc("rst_held", 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("post_rst_idle_a", 0, 0, 1, 0, 0, 0, 0);
      cyc("post_rst_idle_b", 0, 0, 1, 0, 0, 0, 0);
      cyc("ld1", 1, 1, 0, 1, 0, 1, 0);
      cyc("ld1_expire", 0, 0, 1, 0, 1, 0, 1);
      cyc("reload_from_done", 1, 15, 0, 15, 0, 1, 0);
      cyc("run14", 0, 0, 1, 14, 0, 1, 0);
`else
      cyc("rl_ld2", 1, 2, 0, 2, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc("rl_dec", 0, 0, 1, 1, 0, 1, 0);
         cyc("rl_reload", 0, 0, 1, 2, 1, 1, 0);
      end
      cyc("rl_ld1", 1, 1, 0, 1, 0, 1, 0);
      cyc("rl_ld1_tc_a", 0, 0, 1, 1, 1, 1, 0);
      cyc("rl_ld1_tc_b", 0, 0, 1, 1, 1, 1, 0);
      cyc("rl_ld0", 1, 0, 1, 0, 1, 0, 1);
      cyc("rl_done_hold", 0, 0, 1, 0, 0, 0, 1);
`endif
      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
